// File: rtl/sram_model_pkg.sv
// Shared types and helpers for the sky130 1RW+1R SRAM responder model.
package sram_model_pkg;

  localparam int DFLT_DATA_W    = 32;
  localparam int BYTES          = DFLT_DATA_W / 8;
  localparam int MASK_MAX_BYTES = 128;
  localparam int MASK_MAX_W     = MASK_MAX_BYTES * 8;

  typedef enum logic {
    INIT,
    READY
  } fsm_e;

  // Callers zero-extend their mask and truncate the result to their word width.
  function automatic logic [MASK_MAX_W-1:0] expand_mask(input logic [MASK_MAX_BYTES-1:0] m);
    logic [MASK_MAX_W-1:0] bits;
    for (int i = 0; i < MASK_MAX_BYTES; i++) begin
      bits[8*i +: 8] = {8{m[i]}};
    end
    return bits;
  endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-latency delay line for one SRAM read port: {valid, data, collision},
// output data holds its last value until the next valid read completes.
module sram_rd_pipe #(
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              vld_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              coll_i,
  output logic [DATA_W-1:0] data_o,
  output logic              coll_o
);

  logic              vld_s;
  logic              coll_s;
  logic [DATA_W-1:0] data_s;
  logic [DATA_W-1:0] dout_q;
  logic              coll_q;

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic              vld_p0_q;
      logic              coll_p0_q;
      logic [DATA_W-1:0] data_p0_q;

      // stage p0: extra register ahead of the output stage
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          vld_p0_q  <= 1'b0;
          coll_p0_q <= 1'b0;
          data_p0_q <= '0;
        end else begin
          vld_p0_q  <= vld_i;
          coll_p0_q <= coll_i;
          data_p0_q <= data_i;
        end
      end

      assign vld_s  = vld_p0_q;
      assign coll_s = coll_p0_q;
      assign data_s = data_p0_q;
    end else begin : g_lat1
      assign vld_s  = vld_i;
      assign coll_s = coll_i;
      assign data_s = data_i;
    end
  endgenerate

  // output stage: data holds on invalid, collision is a one-cycle pulse
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dout_q <= '0;
      coll_q <= 1'b0;
    end else begin
      if (vld_s) dout_q <= data_s;
      coll_q <= vld_s & coll_s;
    end
  end

  assign data_o = dout_q;
  assign coll_o = coll_q;

endmodule

// File: rtl/sky130_sram_1rw1r_model.sv
// Cycle-accurate responder model of the sky130 1RW+1R SRAM macro with an
// optional post-reset fill so cache contents are deterministic.
module sky130_sram_1rw1r_model
  import sram_model_pkg::*;
#(
  parameter int                DATA_W        = 32,
  parameter int                DEPTH         = 512,
  parameter int                ADDR_W        = 9,
  parameter int                READ_LATENCY  = 1,
  parameter int                INIT_ON_RESET = 1,
  parameter logic [DATA_W-1:0] INIT_WORD     = '0
) (
  input  logic                  ram_clk,
  input  logic                  reset,
  input  logic                  ram_csb0,
  input  logic                  ram_web0,
  input  logic [DATA_W/8-1:0]   ram_wmask0,
  input  logic [ADDR_W-1:0]     ram_addr0,
  input  logic [DATA_W-1:0]     ram_din0,
  output logic [DATA_W-1:0]     ram_dout0,
  input  logic                  ram_csb1,
  input  logic [ADDR_W-1:0]     ram_addr1,
  output logic [DATA_W-1:0]     ram_dout1,
  output logic                  init_done,
  output logic                  collision
);

  logic [DATA_W-1:0] mem [DEPTH];

  fsm_e              state_q;
  logic [ADDR_W-1:0] fill_cnt_q;
  logic              init_done_q;

  logic              ready;
  logic              fill_we;
  logic              in_rng0;
  logic              in_rng1;
  logic              wr_en;
  logic              rd0_vld;
  logic              rd1_vld;
  logic              coll_d;
  logic              coll0;
  logic              coll1;
  logic [DATA_W-1:0] wbits;
  logic [DATA_W-1:0] rd0_data;
  logic [DATA_W-1:0] rd1_data;

  assign ready   = (state_q == READY) && !reset;
  assign fill_we = (state_q == INIT) && !reset;
  assign in_rng0 = 32'(ram_addr0) < DEPTH;
  assign in_rng1 = 32'(ram_addr1) < DEPTH;
  assign wr_en   = ready && !ram_csb0 && !ram_web0 && in_rng0;
  assign rd0_vld = ready && !ram_csb0 && ram_web0;
  assign rd1_vld = ready && !ram_csb1;
  assign coll_d  = wr_en && (ram_addr0 == ram_addr1);
  assign wbits   = DATA_W'(expand_mask(MASK_MAX_BYTES'(ram_wmask0)));

  // Reads sample the array before this edge's write lands (read-before-write).
  assign rd0_data = in_rng0 ? mem[ram_addr0] : '0;
  assign rd1_data = in_rng1 ? mem[ram_addr1] : '0;

  always_ff @(posedge ram_clk) begin
    if (fill_we) begin
      mem[fill_cnt_q] <= INIT_WORD;
    end else if (wr_en) begin
      mem[ram_addr0] <= (mem[ram_addr0] & ~wbits) | (ram_din0 & wbits);
    end
  end

  always_ff @(posedge ram_clk) begin
    if (reset) begin
      fill_cnt_q <= '0;
      if (INIT_ON_RESET != 0) begin
        state_q     <= INIT;
        init_done_q <= 1'b0;
      end else begin
        state_q     <= READY;
        init_done_q <= 1'b1;
      end
    end else if (state_q == INIT) begin
      fill_cnt_q <= fill_cnt_q + ADDR_W'(1);
      if (fill_cnt_q == ADDR_W'(DEPTH - 1)) begin
        state_q     <= READY;
        init_done_q <= 1'b1;
      end
    end
  end

  sram_rd_pipe #(
    .DATA_W      (DATA_W),
    .READ_LATENCY(READ_LATENCY)
  ) u_rd_pipe0 (
    .clk_i (ram_clk),
    .rst_i (reset),
    .vld_i (rd0_vld),
    .data_i(rd0_data),
    .coll_i(1'b0),
    .data_o(ram_dout0),
    .coll_o(coll0)
  );

  sram_rd_pipe #(
    .DATA_W      (DATA_W),
    .READ_LATENCY(READ_LATENCY)
  ) u_rd_pipe1 (
    .clk_i (ram_clk),
    .rst_i (reset),
    .vld_i (rd1_vld),
    .data_i(rd1_data),
    .coll_i(coll_d),
    .data_o(ram_dout1),
    .coll_o(coll1)
  );

  assign collision = coll0 | coll1;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_sky130_sram_1rw1r_model.sv
// Bench for the SRAM model: two instances (512-deep LAT=1 with A5 fill,
// 384-deep LAT=2 with zero fill) share one stimulus stream.
module tb_sky130_sram_1rw1r_model;

  logic        ram_clk;
  logic        reset;
  logic        ram_csb0;
  logic        ram_web0;
  logic [3:0]  ram_wmask0;
  logic [8:0]  ram_addr0;
  logic [31:0] ram_din0;
  logic        ram_csb1;
  logic [8:0]  ram_addr1;
  logic [31:0] dout0_a, dout1_a, dout0_b, dout1_b;
  logic        done_a, done_b, coll_a, coll_b;

  int total = 0;
  int bad   = 0;
  int n     = 0;

  typedef struct {
    int          x;
    bit          p1;
    int          due;
    logic [31:0] d;
    bit          coll;
  } ent_t;

  ent_t        pq[$];
  logic [31:0] mm[2][512];
  int          dep[2];
  int          lat[2];
  logic [31:0] iw[2];
  bit          rdy[2];
  int          fillc[2];
  logic [31:0] e_d0[2];
  logic [31:0] e_d1[2];
  logic        e_coll[2];
  logic        e_done[2];

  sky130_sram_1rw1r_model #(
    .DATA_W(32), .DEPTH(512), .ADDR_W(9), .READ_LATENCY(1),
    .INIT_ON_RESET(1), .INIT_WORD(32'hA5A5_A5A5)
  ) u_dut_a (
    .ram_clk(ram_clk), .reset(reset), .ram_csb0(ram_csb0), .ram_web0(ram_web0),
    .ram_wmask0(ram_wmask0), .ram_addr0(ram_addr0), .ram_din0(ram_din0),
    .ram_dout0(dout0_a), .ram_csb1(ram_csb1), .ram_addr1(ram_addr1),
    .ram_dout1(dout1_a), .init_done(done_a), .collision(coll_a)
  );

  sky130_sram_1rw1r_model #(
    .DATA_W(32), .DEPTH(384), .ADDR_W(9), .READ_LATENCY(2),
    .INIT_ON_RESET(1), .INIT_WORD(32'h0)
  ) u_dut_b (
    .ram_clk(ram_clk), .reset(reset), .ram_csb0(ram_csb0), .ram_web0(ram_web0),
    .ram_wmask0(ram_wmask0), .ram_addr0(ram_addr0), .ram_din0(ram_din0),
    .ram_dout0(dout0_b), .ram_csb1(ram_csb1), .ram_addr1(ram_addr1),
    .ram_dout1(dout1_b), .init_done(done_b), .collision(coll_b)
  );

  initial ram_clk = 1'b0;
  always #5 ram_clk = ~ram_clk;

  task automatic chk(input string tag, input int x, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s dut%0d observed=%h expected=%h at step %0d", tag, x, obs, exp, n);
    end
  endtask

  // One clock: drive inputs, update the reference model for the edge, then compare.
  task automatic step(input logic r, input logic c0, input logic w0, input logic [3:0] m,
                      input logic [8:0] a0, input logic [31:0] d,
                      input logic c1, input logic [8:0] a1);
    ent_t e;
    bit   inr0, inr1, wr;
    reset = r; ram_csb0 = c0; ram_web0 = w0; ram_wmask0 = m;
    ram_addr0 = a0; ram_din0 = d; ram_csb1 = c1; ram_addr1 = a1;
    @(posedge ram_clk);
    n++;
    if (r) pq.delete();
    for (int x = 0; x < 2; x++) begin
      e_coll[x] = 1'b0;
      if (r) begin
        rdy[x] = 0; fillc[x] = 0; e_d0[x] = '0; e_d1[x] = '0; e_done[x] = 1'b0;
      end else if (!rdy[x]) begin
        mm[x][fillc[x]] = iw[x];
        fillc[x]++;
        if (fillc[x] == dep[x]) begin
          rdy[x] = 1; e_done[x] = 1'b1;
        end
      end else begin
        inr0 = int'(a0) < dep[x];
        inr1 = int'(a1) < dep[x];
        wr   = !c0 && !w0 && inr0;
        if (!c0 && w0) begin
          e.x = x; e.p1 = 0; e.due = n + lat[x] - 1; e.d = inr0 ? mm[x][a0] : 32'h0; e.coll = 0;
          pq.push_back(e);
        end
        if (!c1) begin
          e.x = x; e.p1 = 1; e.due = n + lat[x] - 1; e.d = inr1 ? mm[x][a1] : 32'h0;
          e.coll = wr && (a0 == a1);
          pq.push_back(e);
        end
        if (wr) begin
          for (int b = 0; b < 4; b++) if (m[b]) mm[x][a0][8*b +: 8] = d[8*b +: 8];
        end
      end
    end
    for (int i = 0; i < pq.size(); ) begin
      if (pq[i].due <= n) begin
        if (pq[i].p1) begin
          e_d1[pq[i].x] = pq[i].d;
          e_coll[pq[i].x] = e_coll[pq[i].x] | pq[i].coll;
        end else begin
          e_d0[pq[i].x] = pq[i].d;
        end
        pq.delete(i);
      end else begin
        i++;
      end
    end
    #1;
    chk("dout0", 0, dout0_a, e_d0[0]);
    chk("dout1", 0, dout1_a, e_d1[0]);
    chk("collision", 0, 32'(coll_a), 32'(e_coll[0]));
    chk("init_done", 0, 32'(done_a), 32'(e_done[0]));
    chk("dout0", 1, dout0_b, e_d0[1]);
    chk("dout1", 1, dout1_b, e_d1[1]);
    chk("collision", 1, 32'(coll_b), 32'(e_coll[1]));
    chk("init_done", 1, 32'(done_b), 32'(e_done[1]));
  endtask

  initial begin
    logic [8:0] ra0, ra1;
    int         op;
    dep[0] = 512; lat[0] = 1; iw[0] = 32'hA5A5_A5A5;
    dep[1] = 384; lat[1] = 2; iw[1] = 32'h0;

    // reset, then 200 fill cycles with requests that must be ignored
    step(1, 1, 1, 4'h0, 9'h0, 32'h0, 1, 9'h0);
    for (int i = 0; i < 200; i++) begin
      if (i % 2 == 0) step(0, 0, 0, 4'hF, 9'h005, 32'hFFFF_FFFF, 0, 9'h007);
      else            step(0, 0, 1, 4'h0, 9'h005, 32'h0, 0, 9'h007);
      chk("init_dout0", 0, dout0_a, 32'h0);
    end

    // reset pulse at fill_cnt=200 restarts the fill
    step(1, 1, 1, 4'h0, 9'h0, 32'h0, 1, 9'h0);
    for (int i = 1; i <= 511; i++) begin
      step(0, 1, 1, 4'h0, 9'h0, 32'h0, 1, 9'h0);
      if (i == 383) chk("b_done_early", 1, 32'(done_b), 32'h0);
      if (i == 384) chk("b_done_at_384", 1, 32'(done_b), 32'h1);
      if (i == 511) chk("a_done_early", 0, 32'(done_a), 32'h0);
    end
    step(0, 1, 1, 4'h0, 9'h0, 32'h0, 1, 9'h0);
    chk("a_done_at_512", 0, 32'(done_a), 32'h1);

    step(0, 0, 1, 4'h0, 9'h1FF, 32'h0, 1, 9'h0);
    chk("fill_1ff", 0, dout0_a, 32'hA5A5_A5A5);
    step(0, 0, 1, 4'h0, 9'h005, 32'h0, 1, 9'h0);
    chk("ignored_init_write", 0, dout0_a, 32'hA5A5_A5A5);

    // masked write
    step(0, 0, 0, 4'b0101, 9'h010, 32'h1122_3344, 1, 9'h0);
    step(0, 0, 1, 4'h0, 9'h010, 32'h0, 1, 9'h0);
    chk("mask_lat1", 0, dout0_a, 32'hA522_A544);
    step(0, 1, 1, 4'h0, 9'h0, 32'h0, 1, 9'h0);
    chk("mask_lat2", 1, dout0_b, 32'h0022_0044);

    // same-address write/read collision
    step(0, 0, 0, 4'hF, 9'h020, 32'hDEAD_BEEF, 0, 9'h020);
    chk("coll_old_a", 0, dout1_a, 32'hA5A5_A5A5);
    chk("coll_flag_a", 0, 32'(coll_a), 32'h1);
    step(0, 1, 1, 4'h0, 9'h0, 32'h0, 0, 9'h020);
    chk("coll_new_a", 0, dout1_a, 32'hDEAD_BEEF);
    chk("coll_clear_a", 0, 32'(coll_a), 32'h0);
    chk("coll_old_b", 1, dout1_b, 32'h0);
    chk("coll_flag_b", 1, 32'(coll_b), 32'h1);
    step(0, 1, 1, 4'h0, 9'h0, 32'h0, 1, 9'h0);
    chk("coll_new_b", 1, dout1_b, 32'hDEAD_BEEF);
    chk("coll_clear_b", 1, 32'(coll_b), 32'h0);

    // back-to-back reads then hold
    for (int i = 1; i <= 3; i++) step(0, 0, 0, 4'hF, 9'(i), 32'(i), 1, 9'h0);
    for (int i = 1; i <= 3; i++) begin
      step(0, 0, 1, 4'h0, 9'(i), 32'h0, 1, 9'h0);
      chk("b2b_read", 0, dout0_a, 32'(i));
    end
    for (int i = 0; i < 3; i++) step(0, 1, 1, 4'h0, 9'h0, 32'h0, 1, 9'h0);
    chk("hold_a", 0, dout0_a, 32'h3);
    chk("hold_b", 1, dout0_b, 32'h3);

    // zero mask writes nothing
    step(0, 0, 0, 4'h0, 9'h002, 32'hFFFF_FFFF, 1, 9'h0);
    step(0, 0, 1, 4'h0, 9'h002, 32'h0, 1, 9'h0);
    chk("zero_mask", 0, dout0_a, 32'h2);

    // address range boundary
    step(0, 0, 0, 4'hF, 9'h180, 32'h1234_5678, 1, 9'h0);
    step(0, 0, 0, 4'hF, 9'h17F, 32'hCAFE_F00D, 1, 9'h0);
    step(0, 0, 1, 4'h0, 9'h180, 32'h0, 1, 9'h0);
    chk("rng_a_180", 0, dout0_a, 32'h1234_5678);
    step(0, 0, 1, 4'h0, 9'h17F, 32'h0, 1, 9'h0);
    chk("rng_a_17f", 0, dout0_a, 32'hCAFE_F00D);
    chk("rng_b_180", 1, dout0_b, 32'h0);
    step(0, 0, 1, 4'h0, 9'h17F, 32'h0, 0, 9'h17F);
    chk("rng_b_17f", 1, dout0_b, 32'hCAFE_F00D);
    chk("dual_rd_p1", 0, dout1_a, 32'hCAFE_F00D);
    chk("dual_rd_coll", 0, 32'(coll_a), 32'h0);

    // random traffic around the range boundary
    for (int i = 0; i < 300; i++) begin
      op  = int'($urandom_range(0, 3));
      ra0 = 9'h170 + 9'($urandom_range(0, 31));
      ra1 = ($urandom_range(0, 1) == 1) ? ra0 : 9'h170 + 9'($urandom_range(0, 31));
      step(0, op == 0, op == 1, 4'($urandom_range(0, 15)), ra0, $urandom,
           $urandom_range(0, 2) == 0, ra1);
    end
    step(0, 1, 1, 4'h0, 9'h0, 32'h0, 1, 9'h0);
    step(0, 1, 1, 4'h0, 9'h0, 32'h0, 1, 9'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
